// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM states, recoded digit, width/iteration math.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit value = zero ? 0 : (neg ? -1 : +1) * (two ? 2 : 1) * M
    typedef struct packed {
        logic zero;
        logic neg;
        logic two;
    } digit_t;

    function automatic digit_t booth_recode(input logic [2:0] win);
        digit_t d;
        d.zero = (win == 3'b000) || (win == 3'b111);
        d.neg  = win[2] && !d.zero;
        d.two  = (win == 3'b011) || (win == 3'b100);
        return d;
    endfunction

    function automatic int booth_width(input int n);
        return n + 2;
    endfunction

    // Unsigned needs one extra digit to consume the zero-extended top bits.
    function automatic int booth_iters(input int n, input bit uns);
        return uns ? (n / 2 + 1) : (n / 2);
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: 3-bit window {q1, q0, q-1} to {zero, neg, two}; no latency, no flow control.
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] i_win,
    output digit_t     o_digit
);

    assign o_digit = booth_recode(i_win);

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Radix-4 Booth multiplier (BOOTH_MUL_UNSIGNED_EN enables unsigned mode); valid after N/2+1 edges signed, N/2+2 unsigned.
// No backpressure: start is ignored while busy; valid is a one-cycle pulse and Y holds until the next result.
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int NUMBER_OF_BITS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          sign_mode,
    input  logic [NUMBER_OF_BITS-1:0]     M,
    input  logic [NUMBER_OF_BITS-1:0]     Q,
    output logic [2*NUMBER_OF_BITS-1:0]   Y,
    output logic                          valid,
    output logic                          busy
);

    localparam int N  = NUMBER_OF_BITS;
    localparam int W  = booth_width(N);
    localparam int KS = booth_iters(N, 1'b0);
    localparam int KU = booth_iters(N, 1'b1);
    localparam int CW = $clog2(KU + 1);

    if ((N % 2) != 0 || N < 4) begin : g_bad_width
        $error("booth_radix4_multiplier: NUMBER_OF_BITS must be even and >= 4");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [W:0]       r_acc;
    logic [W-1:0]     r_q;
    logic             r_qm1;
    logic [W-1:0]     r_m;
    logic [2*N-1:0]   r_y;
    logic             r_valid;

    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic [W-1:0]     w_m_ext;
    logic [W-1:0]     w_q_ext;
    logic [CW-1:0]    w_k;
    digit_t           w_dig;
    logic [W:0]       w_mult;
    logic [W:0]       w_addend;
    logic [W:0]       w_sum;
    logic [2*W+1:0]   w_shift;
    logic [2*W+1:0]   w_sh;
    logic [2*N-1:0]   w_prod;

    booth_r4_recoder u_recoder (
        .i_win   ({r_q[1:0], r_qm1}),
        .o_digit (w_dig)
    );

    assign w_mult   = w_dig.two ? {r_m, 1'b0} : {r_m[W-1], r_m};
    assign w_addend = w_dig.zero ? '0 : (w_dig.neg ? -w_mult : w_mult);
    assign w_sum    = r_acc + w_addend;
    assign w_shift  = {w_sum, r_q, r_qm1};
    assign w_sh     = $signed(w_shift) >>> 2;

    // After K shifts {acc, q} holds the product scaled by 2^(W-2K): 4 for signed, 1 for unsigned.
`ifdef BOOTH_MUL_UNSIGNED_EN
    logic r_uns;
    logic w_uns;

    assign w_uns   = ~sign_mode;
    assign w_m_ext = w_uns ? {2'b00, M} : {{2{M[N-1]}}, M};
    assign w_q_ext = w_uns ? {2'b00, Q} : {{2{Q[N-1]}}, Q};
    assign w_k     = w_uns ? CW'(KU) : CW'(KS);
    assign w_prod  = r_uns ? w_sh[2*N:1] : w_sh[2*N+2:3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_uns <= 1'b0;
        end else if (w_load) begin
            r_uns <= w_uns;
        end
    end
`else
    logic w_unused_sign;

    assign w_unused_sign = sign_mode;
    assign w_m_ext       = {{2{M[N-1]}}, M};
    assign w_q_ext       = {{2{Q[N-1]}}, Q};
    assign w_k           = CW'(KS);
    assign w_prod        = w_sh[2*N+2:3];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The final iteration edge also writes Y, so a held start in DONE yields one result per K+1 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_CALC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                w_step = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_qm1 <= 1'b0;
            r_m   <= '0;
        end else if (w_load) begin
            r_cnt <= w_k;
            r_acc <= '0;
            r_q   <= w_q_ext;
            r_qm1 <= 1'b0;
            r_m   <= w_m_ext;
        end else if (w_step) begin
            r_cnt <= r_cnt - CW'(1);
            r_acc <= w_sh[2*W+1:W+1];
            r_q   <= w_sh[W:1];
            r_qm1 <= w_sh[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_finish;
            if (w_finish) begin
                r_y <= w_prod;
            end
        end
    end

    assign Y     = r_y;
    assign valid = r_valid;
    assign busy  = (r_state == ST_CALC);

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier (N=8): directed table, handshake corner cases, random regression.
module tb_booth_radix4_multiplier;

    localparam int N = 8;
`ifdef BOOTH_MUL_UNSIGNED_EN
    localparam bit UNS_EN = 1'b1;
`else
    localparam bit UNS_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           sign_mode;
    logic [N-1:0]   M;
    logic [N-1:0]   Q;
    logic [2*N-1:0] Y;
    logic           valid;
    logic           busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic        sm;
        logic [15:0] y;
    } vec_t;

    vec_t tbl[10];

    booth_radix4_multiplier #(.NUMBER_OF_BITS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sign_mode (sign_mode),
        .M         (M),
        .Q         (Q),
        .Y         (Y),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] m, input logic [7:0] q, input logic sm);
        longint a;
        longint b;
        if (sm || !UNS_EN) begin
            a = longint'($signed(m));
            b = longint'($signed(q));
        end else begin
            a = longint'(m);
            b = longint'(q);
        end
        return 16'(a * b);
    endfunction

    function automatic int ref_lat(input logic sm);
        return (!sm && UNS_EN) ? (N / 2 + 2) : (N / 2 + 1);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one operation, scrambles the inputs after acceptance, and checks result and latency.
    task automatic run_op(input logic [7:0] m, input logic [7:0] q, input logic sm,
                          input logic [15:0] exp_y, input string tag);
        int edges;
        @(negedge clk);
        start = 1'b1; M = m; Q = q; sign_mode = sm;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; M = 8'($urandom); Q = 8'($urandom); sign_mode = 1'($urandom);
        edges = 1;
        chk({tag, " busy"}, longint'(busy), 1);
        while (!valid && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        if (!valid) begin
            chk({tag, " timeout"}, 0, 1);
        end else begin
            chk({tag, " Y"}, longint'(Y), longint'(exp_y));
            chk({tag, " latency"}, edges, ref_lat(sm));
            chk({tag, " busy at valid"}, longint'(busy), 0);
        end
    endtask

    initial begin
        int nval;
        int c1;
        int c2;
        logic [15:0] y1;
        logic [15:0] y2;
        logic [7:0] rm;
        logic [7:0] rq;
        logic rs;

        tbl[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        tbl[1] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
        tbl[2] = '{8'hFF, 8'hFF, 1'b0, UNS_EN ? 16'hFE01 : 16'h0001};
        tbl[3] = '{8'h00, 8'hC8, 1'b0, 16'h0000};
        tbl[4] = '{8'h03, 8'hFB, 1'b1, 16'hFFF1};
        tbl[5] = '{8'hF9, 8'h09, 1'b1, 16'hFFC1};
        tbl[6] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        tbl[7] = '{8'h01, 8'hFF, 1'b1, 16'hFFFF};
        tbl[8] = '{8'hC8, 8'h64, 1'b0, UNS_EN ? 16'h4E20 : 16'hEA20};
        tbl[9] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};

        reset = 1'b0; start = 1'b0; sign_mode = 1'b1; M = '0; Q = '0;
        #12;
        chk("reset Y", longint'(Y), 0);
        chk("reset valid", longint'(valid), 0);
        chk("reset busy", longint'(busy), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].m, tbl[i].q, tbl[i].sm, tbl[i].y, $sformatf("vec%0d", i));
        end

        // New start while iterating must be ignored.
        @(negedge clk);
        start = 1'b1; M = 8'h03; Q = 8'hFB; sign_mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        nval = 0;
        y1 = '0;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) begin
                start = 1'b1; M = 8'd100; Q = 8'd100; sign_mode = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                nval++;
                y1 = Y;
            end
        end
        chk("midcalc valid count", nval, 1);
        chk("midcalc Y", longint'(y1), 16'hFFF1);
        chk("midcalc Y held", longint'(Y), 16'hFFF1);

        // Back-to-back: start held through DONE.
        @(negedge clk);
        start = 1'b1; M = 8'h03; Q = 8'hFB; sign_mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        M = 8'hF9; Q = 8'h09;
        nval = 0; c1 = 0; c2 = 0; y1 = '0; y2 = '0;
        for (int c = 1; c < 30 && nval < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                nval++;
                if (nval == 1) begin
                    c1 = c; y1 = Y;
                end else begin
                    c2 = c; y2 = Y; start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b valid count", nval, 2);
        chk("b2b first Y", longint'(y1), 16'hFFF1);
        chk("b2b second Y", longint'(y2), 16'hFFC1);
        chk("b2b spacing", c2 - c1, N / 2 + 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("b2b idle busy", longint'(busy), 0);

        // Reset in the middle of iteration 2 aborts the operation.
        @(negedge clk);
        start = 1'b1; M = 8'h05; Q = 8'h07; sign_mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort Y", longint'(Y), 0);
        chk("abort valid", longint'(valid), 0);
        chk("abort busy", longint'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        nval = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) nval++;
        end
        chk("abort no valid", nval, 0);
        run_op(8'h05, 8'h07, 1'b1, 16'd35, "after abort");

        for (int i = 0; i < 3000; i++) begin
            rm = 8'($urandom);
            rq = 8'($urandom);
            rs = 1'($urandom);
            run_op(rm, rq, rs, ref_mul(rm, rq, rs), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
